cu_command_issue_arbiter: RTL and testbench

- Sits directly downstream of the compute-unit control block.
- Accepts its registered read and write command streams into two per-class FIFOs and round-robin arbitrates them onto the single AFU command interface, gated by a PSL command-credit counter.
- Reports per-class buffer status back upstream; the compute unit throttles on these status signals.

---
 rtl/cu_command_issue_arbiter.sv | 153 +++++++++++++++
 tb/tb_cu_command_issue_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_command_issue_arbiter.sv
// Command issue arbiter: buffers compute-unit read/write command streams and
// round-robins them onto the AFU command interface under PSL credit control.
package cu_command_issue_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic [12:0] command;
      logic [7:0]  tag;
      logic [11:0] size;
      logic [63:0] address;
   } CommandBufferLine;

   typedef struct packed {
      logic       valid;
      logic [7:0] tag;
      logic [7:0] response;
   } ResponseBufferLine;

   typedef struct packed {
      logic empty;
      logic full;
      logic alfull;
   } BufferStatus;

   typedef enum logic {
      CLASS_READ  = 1'b0,
      CLASS_WRITE = 1'b1
   } cmd_class_t;
endpackage

module cu_command_issue_arbiter
   import cu_command_issue_arbiter_pkg::*;
#(
   parameter int unsigned CMD_FIFO_DEPTH = 16,
   parameter int unsigned ALFULL_MARGIN  = 4,
   parameter int unsigned MAX_CREDITS    = 64
) (
   input  logic              clock,
   input  logic              rstn,
   input  logic              enabled_in,
   input  CommandBufferLine  read_command_in,
   input  CommandBufferLine  write_command_in,
   input  ResponseBufferLine response_in,
   output CommandBufferLine  command_out,
   output BufferStatus       read_buffer_status,
   output BufferStatus       write_buffer_status,
   output logic [7:0]        credits_available,
   output logic [1:0]        overflow_error,
   output logic              credit_error
);
   localparam int unsigned AW         = $clog2(CMD_FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL   = (AW+1)'(CMD_FIFO_DEPTH);
   localparam logic [AW:0] ALFULL_LVL = (AW+1)'(CMD_FIFO_DEPTH - ALFULL_MARGIN);
   localparam logic [7:0]  MAX_C      = 8'(MAX_CREDITS);

   CommandBufferLine mem [0:1][0:CMD_FIFO_DEPTH-1];
   CommandBufferLine cmd_in [0:1];
   CommandBufferLine issue_q;
   BufferStatus      status_q [0:1];
   logic [AW-1:0]    wr_ptr [0:1];
   logic [AW-1:0]    rd_ptr [0:1];
   logic [AW:0]      count [0:1];
   logic [AW:0]      count_next [0:1];
   logic [1:0]       has_data, push, pop, accept, ovf;
   logic             enabled_q, eligible, credit_err_set;
   logic [7:0]       credits_q, credits_next;
   cmd_class_t       last_class, grant;
   logic             unused_resp;

   assign unused_resp = ^{response_in.tag, response_in.response};

   always_comb begin
      cmd_in[0] = read_command_in;
      cmd_in[1] = write_command_in;
      has_data  = '0;
      push      = '0;
      for (int unsigned c = 0; c < 2; c++) begin
         has_data[c] = (count[c] != '0);
         push[c]     = cmd_in[c].valid;
      end
      eligible = enabled_q && (credits_q != '0) && (has_data != '0);
      grant    = CLASS_READ;
      if (has_data == 2'b11)
         grant = (last_class == CLASS_READ) ? CLASS_WRITE : CLASS_READ;
      else if (has_data[1])
         grant = CLASS_WRITE;
      pop = '0;
      if (eligible) pop[grant] = 1'b1;
      accept = '0;
      ovf    = '0;
      for (int unsigned c = 0; c < 2; c++) begin
         // a pop in the same cycle frees the slot, so a push at full is still taken
         accept[c]     = push[c] && ((count[c] != FULL_LVL) || pop[c]);
         ovf[c]        = push[c] && !accept[c];
         count_next[c] = count[c] + (AW+1)'(accept[c]) - (AW+1)'(pop[c]);
      end
   end

   always_comb begin
      credits_next   = credits_q;
      credit_err_set = 1'b0;
      if (response_in.valid && !eligible) begin
         if (credits_q == MAX_C) credit_err_set = 1'b1;
         else                    credits_next   = credits_q + 8'd1;
      end else if (!response_in.valid && eligible) begin
         credits_next = credits_q - 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned c = 0; c < 2; c++)
         if (accept[c]) mem[c][wr_ptr[c]] <= cmd_in[c];
   end

   // The granted head lands in issue_q first, then command_out; this extra
   // stage gives the push-to-issue latency of two edges.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         enabled_q      <= 1'b0;
         credits_q      <= MAX_C;
         last_class     <= CLASS_WRITE;
         issue_q        <= '0;
         command_out    <= '0;
         overflow_error <= '0;
         credit_error   <= 1'b0;
         for (int unsigned c = 0; c < 2; c++) begin
            wr_ptr[c]   <= '0;
            rd_ptr[c]   <= '0;
            count[c]    <= '0;
            status_q[c] <= '{empty: 1'b1, full: 1'b0, alfull: 1'b0};
         end
      end else begin
         enabled_q      <= enabled_in;
         credits_q      <= credits_next;
         credit_error   <= credit_error | credit_err_set;
         overflow_error <= overflow_error | ovf;
         if (eligible) last_class <= grant;
         issue_q     <= eligible ? mem[grant][rd_ptr[grant]] : '0;
         command_out <= issue_q;
         for (int unsigned c = 0; c < 2; c++) begin
            count[c] <= count_next[c];
            if (accept[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop[c])    rd_ptr[c] <= rd_ptr[c] + 1'b1;
            status_q[c] <= '{empty:  (count_next[c] == '0),
                             full:   (count_next[c] == FULL_LVL),
                             alfull: (count_next[c] >= ALFULL_LVL)};
         end
      end
   end

   assign read_buffer_status  = status_q[0];
   assign write_buffer_status = status_q[1];
   assign credits_available   = credits_q;
endmodule

// File: tb/tb_cu_command_issue_arbiter.sv
// Directed bench for cu_command_issue_arbiter: default instance plus a
// two-credit instance for credit exhaustion.
module tb_cu_command_issue_arbiter;
   import cu_command_issue_arbiter_pkg::*;

   logic clock = 1'b0;
   logic rstn;
   logic en, en2;
   CommandBufferLine rd, wr, rd2, wr2, cmd_o, cmd_o2;
   ResponseBufferLine resp, resp2;
   BufferStatus rd_st, wr_st, rd_st2, wr_st2;
   logic [7:0] credits, credits2;
   logic [1:0] ovf, ovf2;
   logic cerr, cerr2;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   cu_command_issue_arbiter u_dut (
      .clock(clock), .rstn(rstn), .enabled_in(en),
      .read_command_in(rd), .write_command_in(wr), .response_in(resp),
      .command_out(cmd_o), .read_buffer_status(rd_st), .write_buffer_status(wr_st),
      .credits_available(credits), .overflow_error(ovf), .credit_error(cerr)
   );

   cu_command_issue_arbiter #(.MAX_CREDITS(2)) u_dut_c2 (
      .clock(clock), .rstn(rstn), .enabled_in(en2),
      .read_command_in(rd2), .write_command_in(wr2), .response_in(resp2),
      .command_out(cmd_o2), .read_buffer_status(rd_st2), .write_buffer_status(wr_st2),
      .credits_available(credits2), .overflow_error(ovf2), .credit_error(cerr2)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic CommandBufferLine mk(input logic [7:0] t);
      CommandBufferLine c;
      c         = '0;
      c.valid   = 1'b1;
      c.command = 13'h0A0;
      c.tag     = t;
      c.size    = 12'd128;
      c.address = {48'h0, t, 8'h80};
      return c;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      en = 1'b0; en2 = 1'b0;
      rd = '0; wr = '0; rd2 = '0; wr2 = '0; resp = '0; resp2 = '0;
      @(posedge clock);
      #1;
      rstn = 1'b1;
   endtask

   CommandBufferLine got [0:15];
   int n;

   initial begin
      rstn = 1'b0;
      en = 1'b0; en2 = 1'b0;
      rd = '0; wr = '0; rd2 = '0; wr2 = '0; resp = '0; resp2 = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_cmd", cmd_o, '0);
      check("rst_rdst", rd_st, 3'b100);
      check("rst_wrst", wr_st, 3'b100);
      check("rst_credits", credits, 8'd64);
      check("rst_ovf", ovf, 2'b00);
      check("rst_cerr", cerr, 1'b0);
      rstn = 1'b1;

      // three reads back to back
      en = 1'b1;
      rd = mk(8'd1); tick;
      check("t1_early0", cmd_o.valid, 1'b0);
      rd = mk(8'd2); tick;
      check("t1_early1", cmd_o.valid, 1'b0);
      rd = mk(8'd3); tick;
      rd = '0;
      check("t1_out1", cmd_o, mk(8'd1));
      tick; check("t1_out2", cmd_o, mk(8'd2));
      tick; check("t1_out3", cmd_o, mk(8'd3));
      tick; check("t1_idle", cmd_o.valid, 1'b0);
      check("t1_credits", credits, 8'd61);
      check("t1_rd_empty", rd_st.empty, 1'b1);

      // interleave after queuing with issue disabled
      do_reset;
      for (int i = 0; i < 4; i++) begin
         rd = mk(8'h10 + 8'(i));
         wr = mk(8'h20 + 8'(i));
         tick;
      end
      rd = '0; wr = '0;
      check("t2_noissue", cmd_o.valid, 1'b0);
      en = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick;
         if (cmd_o.valid) begin
            if (n < 16) got[n] = cmd_o;
            n++;
         end
      end
      check("t2_count", n, 8);
      for (int j = 0; j < 8; j++)
         check($sformatf("t2_order%0d", j), got[j],
               (j % 2 == 0) ? mk(8'h10 + 8'(j/2)) : mk(8'h20 + 8'(j/2)));

      // credit exhaustion on the two-credit instance
      do_reset;
      en2 = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         rd2 = mk(8'h30 + 8'(i));
         tick;
         if (cmd_o2.valid) n++;
      end
      rd2 = '0;
      for (int k = 0; k < 10; k++) begin
         tick;
         if (cmd_o2.valid) n++;
      end
      check("t3_issued", n, 2);
      check("t3_credits0", credits2, 8'd0);
      check("t3_rd_nonempty", rd_st2.empty, 1'b0);
      resp2.valid = 1'b1; tick; resp2 = '0;
      check("t3_credits1", credits2, 8'd1);
      check("t3_wait", cmd_o2.valid, 1'b0);
      tick;
      check("t3_credits_back0", credits2, 8'd0);
      tick;
      check("t3_third", cmd_o2, mk(8'h32));
      n = 0;
      for (int k = 0; k < 5; k++) begin
         tick;
         if (cmd_o2.valid) n++;
      end
      check("t3_no_more", n, 0);
      check("t3_errs", {ovf2, cerr2, wr_st2.empty}, 4'b0001);

      // fill the write FIFO, then overflow it
      do_reset;
      for (int i = 1; i <= 16; i++) begin
         wr = mk(8'h40 + 8'(i - 1));
         tick;
         if (i == 11) check("t4_alfull11", wr_st.alfull, 1'b0);
         if (i == 12) check("t4_alfull12", wr_st.alfull, 1'b1);
         if (i == 15) check("t4_full15", wr_st.full, 1'b0);
      end
      wr = '0;
      check("t4_full", wr_st, 3'b011);
      check("t4_ovf0", ovf, 2'b00);
      wr = mk(8'hEE); tick; wr = '0;
      check("t4_ovf1", ovf, 2'b10);
      check("t4_still_full", wr_st.full, 1'b1);
      en = 1'b1;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         tick;
         if (cmd_o.valid) begin
            if (n < 16) got[n] = cmd_o;
            n++;
         end
      end
      check("t4_count", n, 16);
      for (int j = 0; j < 16; j++)
         check($sformatf("t4_order%0d", j), got[j], mk(8'h40 + 8'(j)));
      check("t4_empty", wr_st.empty, 1'b1);

      // issue and return in the same cycle, then a return at the maximum
      do_reset;
      en = 1'b1;
      for (int i = 0; i < 59; i++) begin
         rd = mk(8'(i));
         tick;
      end
      rd = '0;
      repeat (4) tick;
      check("t5_credits5", credits, 8'd5);
      rd = mk(8'h77); tick;
      rd = '0; resp.valid = 1'b1; tick;
      resp = '0;
      check("t5_same_cycle", credits, 8'd5);
      tick;
      check("t5_issued", cmd_o, mk(8'h77));
      check("t5_cerr0", cerr, 1'b0);
      do_reset;
      resp.valid = 1'b1; tick; resp = '0;
      check("t5_cerr1", cerr, 1'b1);
      check("t5_credits_max", credits, 8'd64);

      // asynchronous reset with work queued
      do_reset;
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rd = mk(8'h50 + 8'(i));
         tick;
      end
      rd = '0;
      repeat (4) tick;
      check("t6_credits58", credits, 8'd58);
      en = 1'b0;
      repeat (2) tick;
      for (int i = 0; i < 3; i++) begin
         rd = mk(8'h60 + 8'(i));
         wr = mk(8'h68 + 8'(i));
         tick;
      end
      rd = '0; wr = '0;
      check("t6_queued", {rd_st.empty, wr_st.empty}, 2'b00);
      #2 rstn = 1'b0;
      #1;
      check("t6_cmd0", cmd_o, '0);
      check("t6_empty", {rd_st.empty, wr_st.empty}, 2'b11);
      check("t6_credits", credits, 8'd64);
      tick;
      rstn = 1'b1;
      en = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         if (cmd_o.valid) n++;
      end
      check("t6_no_stale", n, 0);
      check("t6_credits_after", credits, 8'd64);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
